// File: rtl/pio_gen2_pkg.sv
// Shared definitions for the pio_gen2 parallel I/O slave.
// Includes the register word map, the edge-capture modes and the warm-up terminal count.
package pio_gen2_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA    = 3'd0,
    ADDR_DIR     = 3'd1,
    ADDR_IRQMASK = 3'd2,
    ADDR_EDGECAP = 3'd3,
    ADDR_OUTSET  = 3'd4,
    ADDR_OUTCLR  = 3'd5,
    ADDR_RSVD6   = 3'd6,
    ADDR_RSVD7   = 3'd7
  } reg_addr_e;

  localparam int EDGE_NONE = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_FALL = 2;
  localparam int EDGE_ANY  = 3;

  localparam logic [31:0] RSVD_READ   = 32'h0;
  localparam logic [1:0]  WARMUP_DONE = 2'd3;

endpackage

// File: rtl/pio_gen2_if.sv
// Avalon-MM slave port bundle for pio_gen2 (3-bit word address, 32-bit data).
interface pio_gen2_if;

  // Handshake: a write happens on any clock where chipselect & ~write_n (no wait
  // states); a read is accepted when chipselect & ~read_n and its data appears
  // on readdata one clock later, then holds until the next accepted read.
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, read_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, read_n, writedata,
    output readdata
  );

endinterface

// File: rtl/pio_sync_edge.sv
// Pin input path: 2-flop synchroniser, history flop, warm-up counter and
// edge-pulse generation for the selected edge mode.
module pio_sync_edge
  import pio_gen2_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] prev;
  logic [1:0]       warm_cnt;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta     <= '0;
      sync_in  <= '0;
      prev     <= '0;
      warm_cnt <= '0;
    end else begin
      meta    <= in_port;
      sync_in <= meta;
      prev    <= sync_in;
      if (warm_cnt != WARMUP_DONE) begin
        warm_cnt <= warm_cnt + 2'd1;
      end
    end
  end

  // Until the pipeline has been filled with real pin samples, the zeroed
  // flops would look like edges, so detection stays off.
  always_comb begin
    rise       = sync_in & ~prev;
    fall       = ~sync_in & prev;
    edge_pulse = '0;
    if (warm_cnt == WARMUP_DONE) begin
      case (EDGE_TYPE)
        EDGE_RISE: edge_pulse = rise;
        EDGE_FALL: edge_pulse = fall;
        EDGE_ANY:  edge_pulse = rise | fall;
        default:   edge_pulse = '0;
      endcase
    end
  end

endmodule

// File: rtl/pio_gen2.sv
// Parallel I/O slave: output register with atomic set/clear, per-bit direction,
// synchronised input read-back, sticky edge capture and a maskable level irq.
module pio_gen2
  import pio_gen2_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter int               IRQ_EN      = 1
) (
  input  logic             clk,
  input  logic             reset,
  pio_gen2_if.slave        bus,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [WIDTH-1:0] MASK_KEEP = (IRQ_EN != 0) ? '1 : '0;

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] data_view;
  logic [31:0]      rd_next;
  logic             wr_en;
  logic             rd_en;
  reg_addr_e        addr;
  logic             unused_wd;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign rd_en     = bus.chipselect & ~bus.read_n;
  assign addr      = reg_addr_e'(bus.address);
  assign wd        = bus.writedata[WIDTH-1:0];
  assign unused_wd = ^bus.writedata;

  pio_sync_edge #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync_edge (
    .clk        (clk),
    .reset      (reset),
    .in_port    (in_port),
    .sync_in    (sync_in),
    .edge_pulse (edge_pulse)
  );

  assign cap_clr = (wr_en && (addr == ADDR_EDGECAP)) ? wd : '0;

  // Edge set is OR'ed after the clear so a same-cycle edge keeps the bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_port <= RESET_VALUE;
      oe       <= DIR_RESET;
      irqmask  <= '0;
      edgecap  <= '0;
    end else begin
      if (wr_en) begin
        case (addr)
          ADDR_DATA:    out_port <= wd;
          ADDR_DIR:     oe       <= wd;
          ADDR_IRQMASK: irqmask  <= wd & MASK_KEEP;
          ADDR_OUTSET:  out_port <= out_port | wd;
          ADDR_OUTCLR:  out_port <= out_port & ~wd;
          default:      ;
        endcase
      end
      edgecap <= (edgecap & ~cap_clr) | edge_pulse;
    end
  end

  // Reads see register contents before any same-cycle write lands.
  always_comb begin
    data_view = (oe & out_port) | (~oe & sync_in);
    rd_next   = RSVD_READ;
    case (addr)
      ADDR_DATA:    rd_next = 32'(data_view);
      ADDR_DIR:     rd_next = 32'(oe);
      ADDR_IRQMASK: rd_next = 32'(irqmask);
      ADDR_EDGECAP: rd_next = 32'(edgecap);
      default:      rd_next = RSVD_READ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.readdata <= '0;
    end else if (rd_en) begin
      bus.readdata <= rd_next;
    end
  end

  assign irq = (IRQ_EN != 0) && (|(edgecap & irqmask));

endmodule

// File: tb/tb_pio_gen2.sv
// Self-checking bench for pio_gen2: two instances (rising/irq on, falling/irq off)
// sharing one pin bus, a table of register vectors, directed edge/irq sequences and a random phase.
module tb_pio_gen2;
  import pio_gen2_pkg::*;

  localparam logic [7:0] RV_A = 8'hA5;
  localparam logic [7:0] DR_A = 8'h0F;
  localparam logic [7:0] RV_B = 8'h3C;
  localparam logic [7:0] DR_B = 8'hF0;
  localparam logic [7:0] RV_M [2] = '{RV_A, RV_B};
  localparam logic [7:0] DR_M [2] = '{DR_A, DR_B};
  localparam int         ET_M [2] = '{EDGE_RISE, EDGE_FALL};
  localparam int         IE_M [2] = '{1, 0};

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_port;
  logic [7:0] out_a, oe_a, out_b, oe_b;
  logic       irq_a, irq_b;

  always #5 clk = ~clk;

  pio_gen2_if bus_a ();
  pio_gen2_if bus_b ();

  pio_gen2 #(.WIDTH(8), .RESET_VALUE(RV_A), .DIR_RESET(DR_A),
             .EDGE_TYPE(EDGE_RISE), .IRQ_EN(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave), .in_port(in_port),
    .out_port(out_a), .oe(oe_a), .irq(irq_a));

  pio_gen2 #(.WIDTH(8), .RESET_VALUE(RV_B), .DIR_RESET(DR_B),
             .EDGE_TYPE(EDGE_FALL), .IRQ_EN(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave), .in_port(in_port),
    .out_port(out_b), .oe(oe_b), .irq(irq_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_bus(input logic wr, input logic rd, input logic [2:0] a, input logic [31:0] d);
    bus_a.chipselect = wr | rd;  bus_b.chipselect = wr | rd;
    bus_a.write_n    = ~wr;      bus_b.write_n    = ~wr;
    bus_a.read_n     = ~rd;      bus_b.read_n     = ~rd;
    bus_a.address    = a;        bus_b.address    = a;
    bus_a.writedata  = d;        bus_b.writedata  = d;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    set_bus(wr, rd, a, d);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 32'h0);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) idle();
  endtask

  task automatic wr_op(input logic [2:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, a, d);
    idle();
  endtask

  task automatic rd_op(input logic [2:0] a);
    drive(1'b0, 1'b1, a, 32'h0);
    idle();
  endtask

  // ---------------- reference model ----------------
  // Pin samples taken since the last reset (newest last, at most three kept):
  // the read-back value is the sample two clocks old, an edge compares it with
  // the one before, and edges exist only once three real samples are present.
  logic [7:0]  smp [$];
  logic [7:0]  m_out [2], m_dir [2], m_mask [2], m_cap [2];
  logic [31:0] m_rd [2];
  bit          m_valid = 1'b0;

  always @(posedge clk) begin : model
    logic [7:0] s, p, ev, view, clr;
    logic       rd, wr;
    int         n;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_out[i] = RV_M[i]; m_dir[i] = DR_M[i]; m_mask[i] = '0; m_cap[i] = '0; m_rd[i] = '0;
      end
      smp.delete();
      m_valid = 1'b1;
    end else begin
      n  = smp.size();
      s  = (n >= 2) ? smp[n-2] : 8'h00;
      p  = (n >= 3) ? smp[n-3] : 8'h00;
      rd = bus_a.chipselect && !bus_a.read_n;
      wr = bus_a.chipselect && !bus_a.write_n;
      for (int i = 0; i < 2; i++) begin
        ev = 8'h00;
        if (n >= 3) begin
          if (ET_M[i] == EDGE_RISE) ev = s & ~p;
          if (ET_M[i] == EDGE_FALL) ev = ~s & p;
          if (ET_M[i] == EDGE_ANY)  ev = s ^ p;
        end
        view = (m_dir[i] & m_out[i]) | (~m_dir[i] & s);
        if (rd) begin
          case (bus_a.address)
            ADDR_DATA:    m_rd[i] = {24'h0, view};
            ADDR_DIR:     m_rd[i] = {24'h0, m_dir[i]};
            ADDR_IRQMASK: m_rd[i] = {24'h0, m_mask[i]};
            ADDR_EDGECAP: m_rd[i] = {24'h0, m_cap[i]};
            default:      m_rd[i] = 32'h0;
          endcase
        end
        clr = 8'h00;
        if (wr) begin
          case (bus_a.address)
            ADDR_DATA:    m_out[i]  = bus_a.writedata[7:0];
            ADDR_DIR:     m_dir[i]  = bus_a.writedata[7:0];
            ADDR_IRQMASK: m_mask[i] = (IE_M[i] != 0) ? bus_a.writedata[7:0] : 8'h00;
            ADDR_EDGECAP: clr       = bus_a.writedata[7:0];
            ADDR_OUTSET:  m_out[i]  = m_out[i] | bus_a.writedata[7:0];
            ADDR_OUTCLR:  m_out[i]  = m_out[i] & ~bus_a.writedata[7:0];
            default:      ;
          endcase
        end
        m_cap[i] = (m_cap[i] & ~clr) | ev;
      end
      smp.push_back(in_port);
      if (smp.size() > 3) void'(smp.pop_front());
    end
  end

  // ---------------- scoreboard (every cycle) ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("sb_out_a", 32'(out_a), 32'(m_out[0]));
      check("sb_oe_a",  32'(oe_a),  32'(m_dir[0]));
      check("sb_rd_a",  bus_a.readdata, m_rd[0]);
      check("sb_irq_a", 32'(irq_a), 32'(|(m_cap[0] & m_mask[0])));
      check("sb_out_b", 32'(out_b), 32'(m_out[1]));
      check("sb_oe_b",  32'(oe_b),  32'(m_dir[1]));
      check("sb_rd_b",  bus_b.readdata, m_rd[1]);
      check("sb_irq_b", 32'(irq_b), 32'h0);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [7:0]  data;
    logic [7:0]  pin;
    logic [7:0]  exp_out;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{1'b1, ADDR_DATA,    8'h00, 8'hFF, 8'h00, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, ADDR_OUTSET,  8'h81, 8'hFF, 8'h81, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, ADDR_OUTCLR,  8'h01, 8'hFF, 8'h80, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, ADDR_DIR,     8'h00, 8'hFF, 8'h80, 1'b1, 32'h0F};
    tbl[4]  = '{1'b0, ADDR_OUTSET,  8'h00, 8'hFF, 8'h80, 1'b1, 32'h0};
    tbl[5]  = '{1'b0, ADDR_DIR,     8'h00, 8'hFF, 8'h80, 1'b1, 32'h0F};
    tbl[6]  = '{1'b0, ADDR_OUTCLR,  8'h00, 8'hFF, 8'h80, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, ADDR_DIR,     8'hF0, 8'hFF, 8'h80, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, ADDR_DATA,    8'hA0, 8'h05, 8'hA0, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, ADDR_DATA,    8'h00, 8'h05, 8'hA0, 1'b1, 32'hA5};
    tbl[10] = '{1'b0, ADDR_DIR,     8'h00, 8'h05, 8'hA0, 1'b1, 32'hF0};
    tbl[11] = '{1'b0, ADDR_RSVD6,   8'h00, 8'h05, 8'hA0, 1'b1, 32'h0};
    tbl[12] = '{1'b0, ADDR_DIR,     8'h00, 8'h05, 8'hA0, 1'b1, 32'hF0};
    tbl[13] = '{1'b0, ADDR_RSVD7,   8'h00, 8'h05, 8'hA0, 1'b1, 32'h0};
    tbl[14] = '{1'b0, ADDR_DATA,    8'h00, 8'h05, 8'hA0, 1'b1, 32'hA5};
    tbl[15] = '{1'b0, ADDR_IRQMASK, 8'h00, 8'h05, 8'hA0, 1'b1, 32'h0};
  end

  // ---------------- directed + random test ----------------
  initial begin
    reset   = 1'b1;
    in_port = 8'hFF;
    set_bus(1'b0, 1'b0, 3'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_out_a", 32'(out_a), 32'hA5);
    check("rst_oe_a",  32'(oe_a),  32'h0F);
    check("rst_irq_a", 32'(irq_a), 32'h0);
    check("rst_rd_a",  bus_a.readdata, 32'h0);
    check("rst_out_b", 32'(out_b), 32'h3C);
    check("rst_oe_b",  32'(oe_b),  32'hF0);

    idle_n(4);
    rd_op(ADDR_EDGECAP);
    check("warmup_cap_a", bus_a.readdata, 32'h0);
    check("warmup_cap_b", bus_b.readdata, 32'h0);

    for (int i = 0; i < 16; i++) begin
      in_port = tbl[i].pin;
      if (tbl[i].wr) wr_op(tbl[i].addr, 32'(tbl[i].data));
      else           rd_op(tbl[i].addr);
      check($sformatf("vec%0d_out", i), 32'(out_a), 32'(tbl[i].exp_out));
      if (tbl[i].chk_rd) check($sformatf("vec%0d_rd", i), bus_a.readdata, tbl[i].exp_rd);
    end

    // Rising edge on bit1 with irqmask=02: capture and irq after three clocks.
    in_port = 8'h00;
    idle_n(4);
    wr_op(ADDR_EDGECAP, 32'hFF);
    wr_op(ADDR_IRQMASK, 32'h02);
    @(posedge clk); #1 in_port = 8'h02;
    repeat (2) @(posedge clk);
    #1 check("irq_early", 32'(irq_a), 32'h0);
    @(posedge clk);
    #1 check("irq_rise", 32'(irq_a), 32'h1);
    check("irq_b_off", 32'(irq_b), 32'h0);
    rd_op(ADDR_EDGECAP);
    check("cap_rise", bus_a.readdata, 32'h02);

    wr_op(ADDR_EDGECAP, 32'h02);
    check("irq_cleared", 32'(irq_a), 32'h0);
    in_port = 8'h00;
    idle_n(4);
    rd_op(ADDR_EDGECAP);
    check("cap_fall_ignored", bus_a.readdata, 32'h0);
    check("irq_fall", 32'(irq_a), 32'h0);

    // Clear landing in the same cycle as a fresh edge: set wins.
    in_port = 8'h02;
    idle_n(4);
    in_port = 8'h00;
    idle_n(4);
    @(posedge clk); #1 in_port = 8'h02;
    @(posedge clk);
    drive(1'b1, 1'b0, ADDR_EDGECAP, 32'h02);
    idle();
    check("irq_clr_vs_edge", 32'(irq_a), 32'h1);
    rd_op(ADDR_EDGECAP);
    check("cap_clr_vs_edge", bus_a.readdata, 32'h02);
    wr_op(ADDR_EDGECAP, 32'h02);
    check("irq_late_clr", 32'(irq_a), 32'h0);
    rd_op(ADDR_EDGECAP);
    check("cap_late_clr", bus_a.readdata, 32'h0);

    // Masked edge: captured but no irq.
    wr_op(ADDR_IRQMASK, 32'h00);
    in_port = 8'h00;
    idle_n(4);
    in_port = 8'h02;
    idle_n(4);
    check("irq_masked", 32'(irq_a), 32'h0);
    rd_op(ADDR_EDGECAP);
    check("cap_masked", bus_a.readdata, 32'h02);
    wr_op(ADDR_IRQMASK, 32'hFF);
    rd_op(ADDR_IRQMASK);
    check("mask_rd_a", bus_a.readdata, 32'hFF);
    check("mask_rd_b", bus_b.readdata, 32'h0);
    check("irq_b_mask", 32'(irq_b), 32'h0);

    // Reset arriving with a read pending.
    rd_op(ADDR_DIR);
    check("pre_rst_rd", bus_a.readdata, 32'hF0);
    @(posedge clk); #1;
    reset = 1'b1;
    set_bus(1'b0, 1'b1, ADDR_DIR, 32'h0);
    @(posedge clk); #1;
    check("rd_reset", bus_a.readdata, 32'h0);
    reset = 1'b0;
    set_bus(1'b0, 1'b0, 3'd0, 32'h0);

    // Random phase, checked cycle by cycle against the model.
    for (int k = 0; k < 1500; k++) begin
      int op;
      @(posedge clk); #1;
      op = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      reset = ($urandom_range(0, 149) == 0);
      case (op)
        1:       set_bus(1'b1, 1'b0, 3'($urandom_range(0, 7)), $urandom);
        2:       set_bus(1'b0, 1'b1, 3'($urandom_range(0, 7)), 32'h0);
        3:       set_bus(1'b1, 1'b1, 3'($urandom_range(0, 7)), $urandom);
        default: set_bus(1'b0, 1'b0, 3'd0, 32'h0);
      endcase
    end
    @(posedge clk); #1 reset = 1'b0;
    idle_n(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
